contador_jk_ctrl: RTL

Sequencer for a bank of WIDTH JK flip-flop cells forming a counter register. Accepts one command at a time (clear, load, count up, count down), drives the bank's J/K inputs each cycle from the bank's fed-back Q, and supports a runtime modulus with wrap and a terminal-count pulse. It sits between the control logic that issues counter operations and the JK cell bank. The bank is clocked on the same `clk` edge with its pr/clr held inactive.

---
 rtl/contador_jk_ctrl.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/contador_jk_ctrl.sv
// contador_jk_ctrl
// Sequencer for a bank of WIDTH JK flip-flop cells that forms a counter register.
// One command runs at a time: clear, load, count up or count down. The counter
// wraps at a runtime modulus (top + 1) and raises tc on each wrapping cycle.
//
// Ports:
//   clk       clock, rising edge
//   clr       synchronous active-high reset; also clears the bank (j=0, k=1s)
//   start     command strobe, sampled only in IDLE
//   op        00 clear, 01 load, 10 count up, 11 count down
//   steps     number of count cycles (count ops only)
//   top       highest count value (modulus - 1)
//   load_val  value for the load command
//   q_fb      current Q of the JK bank
//   j, k      JK bank inputs, combinational from state and q_fb
//   busy      high in EXEC
//   done      one-cycle pulse in DONE
//   tc        high on every count EXEC cycle that wraps
//   err       sticky bank/shadow mismatch flag
//
// Build option: define JK_CTRL_CHECK_EN to add a shadow register that checks the
// bank follows the commanded values; otherwise err is tied to 0.
module contador_jk_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned STEPW = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [STEPW-1:0] steps,
  input  logic [WIDTH-1:0] top,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             busy,
  output logic             done,
  output logic             tc,
  output logic             err
);

  localparam logic [1:0] OpClear = 2'b00;
  localparam logic [1:0] OpLoad  = 2'b01;
  localparam logic [1:0] OpUp    = 2'b10;
  localparam logic [1:0] OpDown  = 2'b11;

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [STEPW-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] top_q, top_d;
  logic [WIDTH-1:0] load_q, load_d;

  logic [WIDTH-1:0] nxt;
  logic             wrap;

  // Next count value derived from the bank's current Q.
  always_comb begin
    nxt  = q_fb;
    wrap = 1'b0;
    if (op_q == OpUp) begin
      if (q_fb >= top_q) begin
        nxt  = '0;
        wrap = 1'b1;
      end else begin
        nxt = q_fb + 1'b1;
      end
    end else begin
      if (q_fb == '0) begin
        nxt  = top_q;
        wrap = 1'b1;
      end else if (q_fb > top_q) begin
        nxt = top_q;
      end else begin
        nxt = q_fb - 1'b1;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rem_d   = rem_q;
    top_d   = top_q;
    load_d  = load_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_d   = op;
          rem_d  = steps;
          top_d  = top;
          load_d = load_val;
          if (op[1] && (steps == '0)) state_d = StDone;
          else                        state_d = StExec;
        end
      end
      StExec: begin
        if (op_q[1]) begin
          rem_d = rem_q - 1'b1;
          if (rem_q == STEPW'(1)) state_d = StDone;
        end else begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= StIdle;
      op_q    <= OpClear;
      rem_q   <= '0;
      top_q   <= '0;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      top_q   <= top_d;
      load_q  <= load_d;
    end
  end

  // Outputs. clr forces a bank clear on the same edge that resets the FSM.
  always_comb begin
    j    = '0;
    k    = '0;
    busy = 1'b0;
    done = 1'b0;
    tc   = 1'b0;
    if (clr) begin
      k = '1;
    end else begin
      unique case (state_q)
        StExec: begin
          busy = 1'b1;
          unique case (op_q)
            OpClear: k = '1;
            OpLoad: begin
              j = load_q;
              k = ~load_q;
            end
            OpUp, OpDown: begin
              // Toggle only the bits that change.
              j  = q_fb ^ nxt;
              k  = q_fb ^ nxt;
              tc = wrap;
            end
            default: ;
          endcase
        end
        StDone:  done = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef JK_CTRL_CHECK_EN
  logic [WIDTH-1:0] exp_val;
  logic [WIDTH-1:0] shadow_q;
  logic             chk_q;
  logic             err_q;
  logic             mismatch;

  always_comb begin
    unique case (op_q)
      OpClear: exp_val = '0;
      OpLoad:  exp_val = load_q;
      default: exp_val = nxt;
    endcase
  end

  // chk_q marks the shadow as holding a result from this command; the first
  // EXEC cycle has nothing to compare against yet.
  assign mismatch = chk_q && (q_fb != shadow_q) &&
                    (((state_q == StExec) && op_q[1]) || (state_q == StDone));

  always_ff @(posedge clk) begin
    if (clr) begin
      shadow_q <= '0;
      chk_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (state_q == StExec) begin
        shadow_q <= exp_val;
        chk_q    <= 1'b1;
      end else if (state_q == StIdle) begin
        chk_q <= 1'b0;
      end
      if (mismatch) err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
